// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB register-memory completer.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x DATA_W word store: async clear, one write port, one combinational read port.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = APB_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] widx,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] ridx,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Every word clears on reset; a single word is written per enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Read port has no latency so the completion cycle sees the current contents.
  always_comb begin
    rdata = mem[ridx];
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed register memory with fixed wait states.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned       ADDR_W      = APB_ADDR_W,
  parameter int unsigned       DATA_W      = APB_DATA_W,
  parameter int unsigned       DEPTH       = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic              PWRITE,
  input  logic              PSEL,
  input  logic              PENABLE,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA
);

  localparam int unsigned       IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN      = ADDR_W'(4 * DEPTH);
  localparam logic [3:0]        WAIT_INIT = 4'(WAIT_STATES);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wait_q, wait_d;
  logic              pready_q, pready_d;

  logic [ADDR_W-1:0] off;
  logic              hit;
  logic [IDX_W-1:0]  idx;
  logic              done;
  logic              mem_we;
  logic [DATA_W-1:0] rdata;

  // Decode the latched address; misaligned or out-of-window accesses are misses.
  always_comb begin
    off = addr_q - BASE_ADDR;
    hit = (off < SPAN) && (off[1:0] == 2'b00);
    idx = off[IDX_W+1:2];
  end

  // pready_q is only ever set inside a transfer, so this marks the completion cycle.
  always_comb begin
    done = PSEL & PENABLE & pready_q;
  end

  // Next-state: a SETUP cycle (PSEL & !PENABLE) always starts a fresh transfer, which also
  // covers back-to-back; PREADY is precomputed one cycle ahead so it can be registered.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    wait_d   = wait_q;
    pready_d = 1'b0;
    mem_we   = 1'b0;
    if (!PSEL) begin
      // Idle bus, or master abandoned the transfer before completion.
      state_d = APB_IDLE;
    end else if (!PENABLE) begin
      state_d  = APB_SETUP;
      addr_d   = PADDR;
      write_d  = PWRITE;
      wdata_d  = PWDATA;
      wait_d   = WAIT_INIT;
      pready_d = (WAIT_INIT == 4'd0);
    end else begin
      case (state_q)
        APB_SETUP, APB_ACCESS: begin
          if (pready_q) begin
            mem_we  = write_q & hit;
            state_d = APB_IDLE;
          end else begin
            state_d  = APB_ACCESS;
            wait_d   = wait_q - 4'd1;
            pready_d = (wait_q == 4'd1);
          end
        end
        // PENABLE without a preceding SETUP is ignored.
        default: state_d = APB_IDLE;
      endcase
    end
  end

  // State and transfer-context registers; reset aborts any transfer in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= APB_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      wait_q   <= '0;
      pready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      wait_q   <= wait_d;
      pready_q <= pready_d;
    end
  end

  apb_regfile #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_regfile (
    .clk  (PCLK),
    .rst_n(PRESETn),
    .we   (mem_we),
    .widx (idx),
    .wdata(wdata_q),
    .ridx (idx),
    .rdata(rdata)
  );

  // Outputs: read data is driven only in a read completion cycle that hits the window.
  always_comb begin
    PREADY = pready_q;
    PRDATA = (done && !write_q && hit) ? rdata : '0;
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench: three completers (0, 2 and 3 wait states) against a transfer-level model.
module tb_apb_slave_mem;

  localparam int NI    = 3;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [31:0] paddr   [NI];
  logic [31:0] pwdata  [NI];
  logic        pwrite  [NI];
  logic        psel    [NI];
  logic        penable [NI];
  logic        pready  [NI];
  logic [31:0] prdata  [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    apb_slave_mem #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .DEPTH      (DEPTH),
      .BASE_ADDR  (32'h0000_0000),
      .WAIT_STATES((k == 0) ? 0 : (k == 1) ? 2 : 3)
    ) u_dut (
      .PCLK   (clk),
      .PRESETn(rst_n),
      .PADDR  (paddr[k]),
      .PWDATA (pwdata[k]),
      .PWRITE (pwrite[k]),
      .PSEL   (psel[k]),
      .PENABLE(penable[k]),
      .PREADY (pready[k]),
      .PRDATA (prdata[k])
    );
  end

  function automatic int wsof(input int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 3;
  endfunction

  // Window is 16 words starting at byte 0; word accesses only.
  function automatic bit hit_of(input logic [31:0] a);
    return (a < 32'd64) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [3:0] idx_of(input logic [31:0] a);
    return a[5:2];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: a transfer is live from its SETUP cycle; the (WS+1)-th ACCESS cycle completes it.
  logic [31:0] m_mem  [NI][DEPTH];
  bit          m_busy [NI];
  int          m_acc  [NI];
  logic [31:0] m_addr [NI];
  logic [31:0] m_data [NI];
  bit          m_wr   [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) begin
        m_busy[k] <= 1'b0;
        m_acc[k]  <= 0;
        m_mem[k]  <= '{default: '0};
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (psel[k] && !penable[k]) begin
          m_busy[k] <= 1'b1;
          m_acc[k]  <= 0;
          m_addr[k] <= paddr[k];
          m_data[k] <= pwdata[k];
          m_wr[k]   <= pwrite[k];
        end else if (psel[k] && penable[k] && m_busy[k]) begin
          if (m_acc[k] == wsof(k)) begin
            if (m_wr[k] && hit_of(m_addr[k])) m_mem[k][idx_of(m_addr[k])] <= m_data[k];
            m_busy[k] <= 1'b0;
          end else begin
            m_acc[k] <= m_acc[k] + 1;
          end
        end else if (!psel[k]) begin
          m_busy[k] <= 1'b0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of PREADY and PRDATA against the model.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      logic        exp_rdy;
      logic [31:0] exp_rd;
      exp_rdy = m_busy[k] && (m_acc[k] == wsof(k));
      exp_rd  = (exp_rdy && psel[k] && penable[k] && !m_wr[k] && hit_of(m_addr[k])) ?
                m_mem[k][idx_of(m_addr[k])] : 32'h0;
      chk($sformatf("pready[%0d]", k), {31'h0, pready[k]}, {31'h0, exp_rdy});
      chk($sformatf("prdata[%0d]", k), prdata[k], exp_rd);
    end
  end

  // Full transfer; entered just after a posedge, returns just after the completion posedge.
  task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input bit scramble, output logic [31:0] rd, output int cyc);
    bit seen;
    int guard;
    psel[k]    = 1'b1;
    penable[k] = 1'b0;
    pwrite[k]  = wr;
    paddr[k]   = a;
    pwdata[k]  = d;
    cyc  = 1;
    rd   = '0;
    seen = 1'b0;
    @(posedge clk);
    #1;
    penable[k] = 1'b1;
    if (scramble) begin
      paddr[k]  = $urandom;
      pwdata[k] = $urandom;
      pwrite[k] = 1'($urandom);
    end
    guard = 0;
    while (!seen && guard < 40) begin
      @(negedge clk);
      cyc++;
      if (pready[k] === 1'b1) begin
        seen = 1'b1;
        rd   = prdata[k];
      end
      @(posedge clk);
      #1;
      guard++;
    end
    chk($sformatf("xfer_done[%0d]", k), {31'h0, seen}, 32'h1);
  endtask

  // Drops PSEL after n_acc ACCESS cycles, before the completer is ready.
  task automatic xfer_abort(input int k, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input int n_acc);
    psel[k]    = 1'b1;
    penable[k] = 1'b0;
    pwrite[k]  = wr;
    paddr[k]   = a;
    pwdata[k]  = d;
    repeat (n_acc) begin
      @(posedge clk);
      #1;
      penable[k] = 1'b1;
    end
    @(posedge clk);
    #1;
    psel[k]    = 1'b0;
    penable[k] = 1'b0;
  endtask

  task automatic idle(input int k, input int n);
    psel[k]    = 1'b0;
    penable[k] = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] rd;
  int          cyc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      psel[k]    = 1'b0;
      penable[k] = 1'b0;
      pwrite[k]  = 1'b0;
      paddr[k]   = '0;
      pwdata[k]  = '0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset_pready[%0d]", k), {31'h0, pready[k]}, 32'h0);
      chk($sformatf("reset_prdata[%0d]", k), prdata[k], 32'h0);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a pending write clears memory and commits nothing.
    xfer(2, 1'b1, 32'h20, 32'hDEAD_BEEF, 1'b0, rd, cyc);
    psel[2]    = 1'b1;
    penable[2] = 1'b0;
    pwrite[2]  = 1'b1;
    paddr[2]   = 32'h20;
    pwdata[2]  = 32'h0123_4567;
    @(posedge clk);
    #1;
    penable[2] = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_pready", {31'h0, pready[2]}, 32'h0);
    chk("midreset_prdata", prdata[2], 32'h0);
    psel[2]    = 1'b0;
    penable[2] = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    xfer(2, 1'b0, 32'h20, 32'h0, 1'b0, rd, cyc);
    chk("midreset_readback", rd, 32'h0);
    idle(2, 1);

    // Zero wait states: write then immediately read the same word.
    xfer(0, 1'b1, 32'h8, 32'hA5A5_0001, 1'b0, rd, cyc);
    chk("zw_write_cycles", 32'(cyc), 32'd2);
    xfer(0, 1'b0, 32'h8, 32'h0, 1'b0, rd, cyc);
    chk("zw_read_cycles", 32'(cyc), 32'd2);
    chk("zw_read_data", rd, 32'hA5A5_0001);
    idle(0, 1);

    // Three wait states: five cycles from SETUP to completion.
    xfer(2, 1'b1, 32'h4, 32'h0BAD_F00D, 1'b0, rd, cyc);
    chk("ws3_write_cycles", 32'(cyc), 32'd5);
    idle(2, 1);
    xfer(2, 1'b0, 32'h4, 32'h0, 1'b0, rd, cyc);
    chk("ws3_read_cycles", 32'(cyc), 32'd5);
    chk("ws3_read_data", rd, 32'h0BAD_F00D);
    idle(2, 1);

    // Back-to-back on the two-wait-state completer: no idle cycle between transfers.
    for (int i = 0; i < 4; i++) begin
      xfer(1, 1'b1, 32'(4 * i), 32'h1000_0000 + 32'(i), 1'b0, rd, cyc);
      chk($sformatf("b2b_write_cycles_%0d", i), 32'(cyc), 32'd4);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(1, 1'b0, 32'(4 * i), 32'h0, 1'b0, rd, cyc);
      chk($sformatf("b2b_read_cycles_%0d", i), 32'(cyc), 32'd4);
      chk($sformatf("b2b_read_data_%0d", i), rd, 32'h1000_0000 + 32'(i));
    end
    idle(1, 1);

    // Decode misses still complete but leave memory untouched.
    xfer(0, 1'b1, 32'h40, 32'hFFFF_FFFF, 1'b0, rd, cyc);
    chk("miss_range_cycles", 32'(cyc), 32'd2);
    xfer(0, 1'b1, 32'h6, 32'hFFFF_FFFF, 1'b0, rd, cyc);
    chk("miss_align_cycles", 32'(cyc), 32'd2);
    xfer(0, 1'b0, 32'h40, 32'h0, 1'b0, rd, cyc);
    chk("miss_range_read", rd, 32'h0);
    xfer(0, 1'b0, 32'h6, 32'h0, 1'b0, rd, cyc);
    chk("miss_align_read", rd, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      xfer(0, 1'b0, 32'(4 * i), 32'h0, 1'b0, rd, cyc);
      chk($sformatf("miss_word_%0d", i), rd, (i == 2) ? 32'hA5A5_0001 : 32'h0);
    end
    idle(0, 1);

    // PENABLE with no preceding SETUP is ignored.
    psel[0]    = 1'b1;
    penable[0] = 1'b1;
    pwrite[0]  = 1'b0;
    paddr[0]   = 32'h8;
    repeat (2) begin
      @(negedge clk);
      chk("stray_penable_pready", {31'h0, pready[0]}, 32'h0);
      chk("stray_penable_prdata", prdata[0], 32'h0);
      @(posedge clk);
      #1;
    end
    idle(0, 1);

    // PSEL dropped in the second ACCESS cycle of a two-wait-state write.
    xfer(1, 1'b1, 32'h10, 32'h5555_AAAA, 1'b0, rd, cyc);
    idle(1, 1);
    xfer_abort(1, 1'b1, 32'h10, 32'hDEAD_0000, 1);
    @(negedge clk);
    chk("abort_pready", {31'h0, pready[1]}, 32'h0);
    @(posedge clk);
    #1;
    idle(1, 1);
    xfer(1, 1'b0, 32'h10, 32'h0, 1'b0, rd, cyc);
    chk("abort_readback", rd, 32'h5555_AAAA);
    idle(1, 1);

    // Random traffic; the compare process checks every cycle against the model.
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 60; n++) begin
        logic [31:0] a;
        bit          wr;
        if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(0, 255));
        else a = 32'($urandom_range(0, 15)) << 2;
        wr = 1'($urandom);
        if (wsof(k) > 0 && $urandom_range(0, 9) == 0) begin
          xfer_abort(k, wr, a, $urandom, $urandom_range(1, wsof(k)));
          idle(k, 1);
        end else begin
          xfer(k, wr, a, $urandom, ($urandom_range(0, 3) == 0), rd, cyc);
          chk($sformatf("rand_cycles[%0d]", k), 32'(cyc), 32'(2 + wsof(k)));
          idle(k, $urandom_range(0, 2));
        end
      end
      idle(k, 1);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
